// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: stall masks, FSM state codes, address type.
// Optional stall watchdog is enabled by defining PIPE_CTRL_WATCHDOG_EN.
package pipe_ctrl_pkg;

   localparam int ADDR_W = 32;
   typedef logic [ADDR_W-1:0] addr_t;

   // stall bit order: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      PCTRL_RUN   = 2'd0,
      PCTRL_STALL = 2'd1,
      PCTRL_FLUSH = 2'd2
   } pctrl_state_e;

   // The deepest requesting stage freezes itself and everything upstream of it.
   function automatic logic [5:0] stall_mask(input logic req_id, input logic req_ex,
                                             input logic req_mem);
      logic [5:0] m;
      if (req_mem)     m = STALL_MEM;
      else if (req_ex) m = STALL_EX;
      else if (req_id) m = STALL_ID;
      else             m = STALL_NONE;
      return m;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages (master) and the sequencer (slave).
interface pipe_ctrl_if;
   import pipe_ctrl_pkg::*;

   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        id_br_req;
   addr_t       id_br_addr;
   logic        excp_req;
   addr_t       excp_vector;
   logic [5:0]  stall;
   logic        flush;
   logic        branchEN;
   addr_t       branchAddr;
   logic        wdt_timeout;

   modport master (
      output stallreq_id, stallreq_ex, stallreq_mem, id_br_req, id_br_addr, excp_req, excp_vector,
      input  stall, flush, branchEN, branchAddr, wdt_timeout
   );

   modport slave (
      input  stallreq_id, stallreq_ex, stallreq_mem, id_br_req, id_br_addr, excp_req, excp_vector,
      output stall, flush, branchEN, branchAddr, wdt_timeout
   );

endinterface

// File: rtl/pipe_ctrl_redirect_hold.sv
// Redirect mux into pc: exception vector, deferred branch, or live branch; holds one branch
// target while pc is stalled so a single-cycle branch pulse is never lost.
module pipe_ctrl_redirect_hold
   import pipe_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  excp_req_i,
   input  addr_t excp_vector_i,
   input  logic  flush_i,
   input  logic  stall_pc_i,
   input  logic  br_req_i,
   input  addr_t br_addr_i,
   output logic  branch_en_o,
   output addr_t branch_addr_o
);

   logic  pend_vld_q, pend_vld_d;
   addr_t pend_addr_q, pend_addr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_vld_q  <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   always_comb begin
      branch_en_o   = 1'b0;
      branch_addr_o = '0;
      pend_vld_d    = pend_vld_q;
      pend_addr_d   = pend_addr_q;
      if (excp_req_i) begin
         branch_en_o   = 1'b1;
         branch_addr_o = excp_vector_i;
         pend_vld_d    = 1'b0;
      end else if (flush_i) begin
         pend_vld_d = 1'b0;
      end else if (pend_vld_q && !stall_pc_i) begin
         // A branch arriving while the old one drains becomes the next pending target.
         branch_en_o   = 1'b1;
         branch_addr_o = pend_addr_q;
         pend_vld_d    = br_req_i;
         if (br_req_i) pend_addr_d = br_addr_i;
      end else if (br_req_i && !stall_pc_i && !pend_vld_q) begin
         branch_en_o   = 1'b1;
         branch_addr_o = br_addr_i;
      end else if (br_req_i) begin
         pend_vld_d  = 1'b1;
         pend_addr_d = br_addr_i;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, runs the exception flush, drives the pc redirect.
// Define PIPE_CTRL_WATCHDOG_EN to add the sticky stall watchdog (wdt_timeout), otherwise tied to 0.
//
// state       | meaning
// PCTRL_RUN   | no stall request, pipeline advancing
// PCTRL_STALL | at least one stage stall request active
// PCTRL_FLUSH | exception flush in progress, stalls and branches suppressed
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned WDT_LIMIT    = 1024
) (
   input  logic      clk,
   input  logic      rst,
   pipe_ctrl_if.slave bus
);

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_param
      $error("pipe_ctrl: FLUSH_CYCLES must be 1..15 and WDT_LIMIT 1..65535");
   end

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   pctrl_state_e state_q, state_d;
   logic [3:0]   fcnt_q, fcnt_d;
   logic         stall_any;
   logic         in_flush;
   logic [5:0]   stall_vec;

   assign stall_any = bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PCTRL_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (bus.excp_req) begin
         state_d = PCTRL_FLUSH;
         fcnt_d  = FLUSH_LOAD;
      end else begin
         case (state_q)
            PCTRL_RUN:   if (stall_any) state_d = PCTRL_STALL;
            PCTRL_STALL: if (!stall_any) state_d = PCTRL_RUN;
            PCTRL_FLUSH: begin
               if (fcnt_q == 4'd0) state_d = stall_any ? PCTRL_STALL : PCTRL_RUN;
               else                fcnt_d  = fcnt_q - 4'd1;
            end
            default:     state_d = PCTRL_RUN;
         endcase
      end
   end

   always_comb begin
      in_flush  = (state_q == PCTRL_FLUSH);
      stall_vec = STALL_NONE;
      if (!bus.excp_req && !in_flush)
         stall_vec = stall_mask(bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
   end

   assign bus.stall = stall_vec;
   assign bus.flush = bus.excp_req | in_flush;

   pipe_ctrl_redirect_hold u_redirect (
      .clk           (clk),
      .rst           (rst),
      .excp_req_i    (bus.excp_req),
      .excp_vector_i (bus.excp_vector),
      .flush_i       (in_flush),
      .stall_pc_i    (stall_vec[0]),
      .br_req_i      (bus.id_br_req),
      .br_addr_i     (bus.id_br_addr),
      .branch_en_o   (bus.branchEN),
      .branch_addr_o (bus.branchAddr)
   );

`ifdef PIPE_CTRL_WATCHDOG_EN
   logic [15:0] wdt_cnt_q, wdt_cnt_d;
   logic        wdt_q, wdt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt_q <= '0;
         wdt_q     <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         wdt_q     <= wdt_d;
      end
   end

   // stall_vec[0] is already low in FLUSH, so one condition covers both clears.
   always_comb begin
      wdt_cnt_d = '0;
      if (stall_vec[0]) wdt_cnt_d = (wdt_cnt_q == 16'hFFFF) ? wdt_cnt_q : wdt_cnt_q + 16'd1;
      wdt_d = wdt_q | (wdt_cnt_d >= 16'(WDT_LIMIT));
   end

   assign bus.wdt_timeout = wdt_q;
`else
   assign bus.wdt_timeout = 1'b0;
`endif

endmodule
